fdivsqrt_otfc4_seq: RTL and testbench

//  Sequential radix-4 on-the-fly converter that consumes one-hot redundant quotient/root digits
//  {2,1,0,-1,-2} from the unified digit-selection logic. It builds the binary result U and its

---
 rtl/fdivsqrt_pkg.sv | 21 ++
 rtl/fdivsqrt_otfc4_seq_if.sv | 27 ++
 rtl/fdivsqrt_otfc4_step.sv | 45 ++++
 rtl/fdivsqrt_otfc4_seq.sv | 103 ++++++++++
 tb/tb_fdivsqrt_otfc4_seq.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fdivsqrt_pkg.sv
// Shared types and constants for the radix-4 divide/sqrt datapath:
// one-hot digit encodings, converter FSM states and a digit-legality helper.
package fdivsqrt_pkg;

    localparam logic [3:0] UDIG_P2 = 4'b1000;
    localparam logic [3:0] UDIG_P1 = 4'b0100;
    localparam logic [3:0] UDIG_M1 = 4'b0010;
    localparam logic [3:0] UDIG_M2 = 4'b0001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        WAITREM = 2'd2
    } otfc_state_t;

    // More than one bit hot means the selector produced a corrupt digit.
    function automatic logic udig_multi_hot(input logic [3:0] d);
        return ((d & (d - 4'd1)) != 4'd0);
    endfunction

endpackage

// File: rtl/fdivsqrt_otfc4_seq_if.sv
// Digit/remainder handshake between the digit selector and the on-the-fly converter.
interface fdivsqrt_otfc4_seq_if #(parameter int W = 30);
    logic         start;
    logic         sqrt_i;
    logic         dig_valid;
    logic [3:0]   udigit;
    logic         dig_ready;
    logic         j0;
    logic         j1;
    logic         sqrt_o;
    logic         rem_valid;
    logic         rem_neg;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         dig_err;

    modport master (
        output start, sqrt_i, dig_valid, udigit, rem_valid, rem_neg,
        input  dig_ready, j0, j1, sqrt_o, busy, done, result, dig_err
    );

    modport slave (
        input  start, sqrt_i, dig_valid, udigit, rem_valid, rem_neg,
        output dig_ready, j0, j1, sqrt_o, busy, done, result, dig_err
    );
endinterface

// File: rtl/fdivsqrt_otfc4_step.sv
// One radix-4 on-the-fly conversion step: appends a signed digit to U and UM
// (UM = U-1) using only shifts and selection, no carry chain.
module fdivsqrt_otfc4_step
    import fdivsqrt_pkg::*;
#(
    parameter int W = 30
) (
    input  logic [W-1:0] u_s,
    input  logic [W-1:0] um_s,
    input  logic [3:0]   udigit_s,
    output logic [W-1:0] u_nxt_s,
    output logic [W-1:0] um_nxt_s,
    output logic         illegal_s
);

    // Select the next U/UM pair; zero and corrupt digits share the d=0 path.
    always_comb begin
        u_nxt_s   = {u_s[W-3:0], 2'b00};
        um_nxt_s  = {um_s[W-3:0], 2'b11};
        illegal_s = udig_multi_hot(udigit_s);
        case (udigit_s)
            UDIG_P2: begin
                u_nxt_s  = {u_s[W-3:0], 2'b10};
                um_nxt_s = {u_s[W-3:0], 2'b01};
            end
            UDIG_P1: begin
                u_nxt_s  = {u_s[W-3:0], 2'b01};
                um_nxt_s = {u_s[W-3:0], 2'b00};
            end
            UDIG_M1: begin
                u_nxt_s  = {um_s[W-3:0], 2'b11};
                um_nxt_s = {um_s[W-3:0], 2'b10};
            end
            UDIG_M2: begin
                u_nxt_s  = {um_s[W-3:0], 2'b10};
                um_nxt_s = {um_s[W-3:0], 2'b01};
            end
            default: begin
                u_nxt_s  = {u_s[W-3:0], 2'b00};
                um_nxt_s = {um_s[W-3:0], 2'b11};
            end
        endcase
    end

endmodule

// File: rtl/fdivsqrt_otfc4_seq.sv
// Sequential radix-4 on-the-fly converter: accumulates DIGITS signed digits into U/UM
// and returns U or U-1 depending on the sign of the final remainder.
module fdivsqrt_otfc4_seq
    import fdivsqrt_pkg::*;
#(
    parameter int DIGITS = 14
) (
    input  logic                  clk,
    input  logic                  resetn,
    fdivsqrt_otfc4_seq_if.slave   bus
);

    localparam int W  = 2 * DIGITS + 2;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

    otfc_state_t   state_r;
    logic [W-1:0]  u_r;
    logic [W-1:0]  um_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  result_r;
    logic          done_r;
    logic          sqrt_r;
    logic          dig_err_r;

    logic [W-1:0]  u_nxt_s;
    logic [W-1:0]  um_nxt_s;
    logic          illegal_s;
    logic          run_s;

    fdivsqrt_otfc4_step #(.W(W)) u_step (
        .u_s       (u_r),
        .um_s      (um_r),
        .udigit_s  (bus.udigit),
        .u_nxt_s   (u_nxt_s),
        .um_nxt_s  (um_nxt_s),
        .illegal_s (illegal_s)
    );

    // Converter FSM, digit accumulation and result capture; start overrides everything.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= IDLE;
            u_r       <= '0;
            um_r      <= '1;
            cnt_r     <= '0;
            result_r  <= '0;
            done_r    <= 1'b0;
            sqrt_r    <= 1'b0;
            dig_err_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.start) begin
                state_r   <= RUN;
                u_r       <= '0;
                um_r      <= '1;
                cnt_r     <= '0;
                sqrt_r    <= bus.sqrt_i;
                dig_err_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    RUN: begin
                        if (bus.dig_valid) begin
                            u_r   <= u_nxt_s;
                            um_r  <= um_nxt_s;
                            cnt_r <= cnt_r + CW'(1);
                            if (illegal_s) begin
                                dig_err_r <= 1'b1;
                            end
                            if (cnt_r == LAST_CNT) begin
                                state_r <= WAITREM;
                            end
                        end
                    end
                    WAITREM: begin
                        if (bus.rem_valid) begin
                            result_r <= bus.rem_neg ? um_r : u_r;
                            done_r   <= 1'b1;
                            state_r  <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign run_s         = (state_r == RUN);
    assign bus.dig_ready = run_s;
    assign bus.busy      = (state_r != IDLE);
    assign bus.j0        = run_s && (cnt_r == CW'(0));
    assign bus.j1        = run_s && (cnt_r == CW'(1));
    assign bus.sqrt_o    = sqrt_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.dig_err   = dig_err_r;

endmodule

// File: tb/tb_fdivsqrt_otfc4_seq.sv
// Directed bench for the radix-4 on-the-fly converter (DIGITS=4): arithmetic model of U/UM,
// result scoreboard fed at remainder time and drained by a done monitor.
module tb_fdivsqrt_otfc4_seq;
    import fdivsqrt_pkg::*;

    localparam int DIGITS = 4;
    localparam int W      = 2 * DIGITS + 2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fdivsqrt_otfc4_seq_if #(.W(W)) bus ();

    fdivsqrt_otfc4_seq #(.DIGITS(DIGITS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int done_cnt = 0;
    int done_before;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mu;
    logic [W-1:0] mum;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] enc(input int d);
        case (d)
            2:       return 4'b1000;
            1:       return 4'b0100;
            -1:      return 4'b0010;
            -2:      return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // Scoreboard drain: every done must have a pending expected result.
    always @(negedge clk) begin
        if (resetn && bus.done === 1'b1) begin
            done_cnt++;
            check("done_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("result_sb", bus.result, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic s);
        bus.start  = 1'b1;
        bus.sqrt_i = s;
        tick();
        bus.start  = 1'b0;
        mu  = '0;
        mum = '1;
    endtask

    task automatic send_raw(input logic [3:0] code, input int dval, input int gap);
        repeat (gap) tick();
        bus.dig_valid = 1'b1;
        bus.udigit    = code;
        tick();
        bus.dig_valid = 1'b0;
        bus.udigit    = 4'b0000;
        mu  = mu * 10'd4 + 10'(dval);
        mum = mu - 10'd1;
        check("u_model", dut.u_r, mu);
        check("um_is_u_minus_1", dut.um_r, mum);
    endtask

    task automatic send(input int d, input int gap);
        send_raw(enc(d), d, gap);
    endtask

    task automatic finish_op(input logic neg, input int want);
        exp_q.push_back(neg ? mum : mu);
        bus.rem_valid = 1'b1;
        bus.rem_neg   = neg;
        tick();
        bus.rem_valid = 1'b0;
        bus.rem_neg   = 1'b0;
        check("done_latency", bus.done, 1);
        check("result_const", bus.result, want);
        tick();
        check("done_one_cycle", bus.done, 0);
        check("busy_after_done", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.sqrt_i = 1'b0; bus.dig_valid = 1'b0; bus.udigit = 4'b0000;
        bus.rem_valid = 1'b0; bus.rem_neg = 1'b0;
        mu = '0; mum = '1;
        repeat (2) tick();
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.dig_ready, 0);
        check("rst_j0j1", {bus.j0, bus.j1}, 0);
        check("rst_sqrt_o", bus.sqrt_o, 0);
        check("rst_dig_err", bus.dig_err, 0);
        check("rst_result", bus.result, 0);
        check("rst_um", dut.um_r, 10'h3FF);
        resetn = 1'b1;
        tick();

        // 1. basic divide, both remainder signs
        done_before = done_cnt;
        do_start(1'b0);
        check("busy_run", bus.busy, 1);
        check("ready_run", bus.dig_ready, 1);
        send(2, 0); send(-1, 0); send(0, 0); send(1, 0);
        check("ready_waitrem", bus.dig_ready, 0);
        finish_op(1'b0, 113);
        check("done_once", done_cnt - done_before, 1);
        do_start(1'b0);
        send(2, 0); send(-1, 0); send(0, 0); send(1, 0);
        finish_op(1'b1, 112);

        // 2. all ones and repeated negative digits
        do_start(1'b0);
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        finish_op(1'b0, 85);
        do_start(1'b0);
        send(2, 0); send(-2, 0); send(-2, 0); send(-2, 0);
        finish_op(1'b0, 86);

        // 3. sqrt op with step flags
        do_start(1'b1);
        for (int i = 0; i < DIGITS; i++) begin
            check("j0", bus.j0, (i == 0) ? 1 : 0);
            check("j1", bus.j1, (i == 1) ? 1 : 0);
            check("sqrt_o", bus.sqrt_o, 1);
            send((i == 0) ? 1 : 0, 0);
        end
        check("j_waitrem", {bus.j0, bus.j1}, 0);
        finish_op(1'b0, 64);
        check("sqrt_o_held", bus.sqrt_o, 1);

        // 4. gaps in dig_valid; stray rem_valid during RUN ignored
        do_start(1'b0);
        send(2, 3);
        bus.rem_valid = 1'b1; tick(); bus.rem_valid = 1'b0;
        check("rem_ignored_in_run", bus.done, 0);
        send(-1, 3); send(0, 3); send(1, 3);
        finish_op(1'b0, 113);

        // 5. illegal multi-hot digit
        do_start(1'b0);
        send(1, 0);
        send_raw(4'b1100, 0, 0);
        check("dig_err_set", bus.dig_err, 1);
        send(1, 0); send(1, 0);
        check("dig_err_sticky", bus.dig_err, 1);
        finish_op(1'b0, 69);
        do_start(1'b0);
        check("dig_err_cleared", bus.dig_err, 0);

        // 6. abort by start (with a colliding digit), then a full op
        done_before = done_cnt;
        send(2, 0); send(1, 0);
        bus.start = 1'b1; bus.sqrt_i = 1'b0; bus.dig_valid = 1'b1; bus.udigit = enc(2);
        tick();
        bus.start = 1'b0; bus.dig_valid = 1'b0; bus.udigit = 4'b0000;
        mu = '0; mum = '1;
        check("abort_u_cleared", dut.u_r, 0);
        check("abort_j0", bus.j0, 1);
        tick();
        check("abort_no_done", done_cnt - done_before, 0);
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        finish_op(1'b1, 84);

        // reset in the middle of a sqrt op
        do_start(1'b1);
        send(2, 0); send(-1, 0);
        resetn = 1'b0;
        tick();
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_ready", bus.dig_ready, 0);
        check("mid_rst_j0j1", {bus.j0, bus.j1}, 0);
        check("mid_rst_sqrt_o", bus.sqrt_o, 0);
        check("mid_rst_dig_err", bus.dig_err, 0);
        check("mid_rst_result", bus.result, 0);
        check("mid_rst_state", 32'(dut.state_r), 32'(IDLE));
        resetn = 1'b1;
        repeat (3) tick();
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
